// File: rtl/mux_pkg.sv
// Shared constants and helpers for the 8-to-1 round-robin collector.
package mux_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned SEL_W  = 3;

    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (oh[i]) idx = idx | SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// Rotating-priority arbiter over 8 requesters; the pointer moves past the winner on advance.
module rr_arbiter8
    import mux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              any_grant
);

    logic [SEL_W-1:0] ptr_q, ptr_d;

    // Scan upward from the pointer; the 3-bit add wraps 7 -> 0 naturally.
    always_comb begin
        logic [SEL_W-1:0] idx;
        idx   = '0;
        grant = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            idx = ptr_q + SEL_W'(j);
            if (grant == '0 && req[idx]) grant[idx] = 1'b1;
        end
    end

    assign grant_idx = onehot_to_idx(grant);
    assign any_grant = |grant;

    always_comb begin
        ptr_d = ptr_q;
        if (advance) ptr_d = grant_idx + SEL_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/rr_mux8to1.sv
// 8-to-1 round-robin gather stage: one registered output word tagged with its source channel.
module rr_mux8to1
    import mux_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    input  logic                     out_ready
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;

    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              any_grant;
    logic              can_load;
    logic [DATA_W-1:0] sel_data;

    assign can_load = !out_valid_q || out_ready;

    rr_arbiter8 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (can_load && any_grant),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Grant is one-hot, so an AND-OR select is sufficient.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) sel_data = sel_data | in_data[i*DATA_W +: DATA_W];
        end
    end

    // The register is empty during reset, so gate on rst to keep in_ready low then.
    assign in_ready = (can_load && !rst) ? grant : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (can_load) begin
            out_valid_d = any_grant;
            if (any_grant) begin
                out_data_d = sel_data;
                out_sel_d  = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux8to1.sv
// Self-checking bench for rr_mux8to1: vector table plus scoreboarded round-robin sequence.
module tb_rr_mux8to1;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [7:0]    in_valid;
    logic [8*DW-1:0] in_data;
    logic [7:0]    in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [2:0]    out_sel;
    logic          out_ready;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [7:0] v;
        logic       r;
        logic [7:0] ir;
        logic       ov;
        logic [2:0] sel;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [2:0] sel;
    } exp_t;

    vec_t tab[16];
    exp_t sb[$];

    rr_mux8to1 #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] chdata(input int i);
        logic [7:0] d;
        d = 8'(8'h10 + i);
        if (i == 5) d = 8'hA5;
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        in_data = '0;
        for (int i = 0; i < 8; i++) in_data[i*DW +: DW] = chdata(i);

        // Sequence from reset: single channel, idle, drain+load alternation,
        // backpressure with pointer at 3, idle then pointer-hold check.
        tab[0]  = '{8'h20, 1'b1, 8'h20, 1'b1, 3'd5};
        tab[1]  = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd5};
        tab[2]  = '{8'h0C, 1'b1, 8'h04, 1'b1, 3'd2};
        tab[3]  = '{8'h0C, 1'b1, 8'h08, 1'b1, 3'd3};
        tab[4]  = '{8'h0C, 1'b1, 8'h04, 1'b1, 3'd2};
        tab[5]  = '{8'h0C, 1'b1, 8'h08, 1'b1, 3'd3};
        tab[6]  = '{8'h0C, 1'b1, 8'h04, 1'b1, 3'd2};
        tab[7]  = '{8'h81, 1'b0, 8'h00, 1'b1, 3'd2};
        tab[8]  = '{8'h81, 1'b0, 8'h00, 1'b1, 3'd2};
        tab[9]  = '{8'h81, 1'b0, 8'h00, 1'b1, 3'd2};
        tab[10] = '{8'h81, 1'b1, 8'h80, 1'b1, 3'd7};
        tab[11] = '{8'h81, 1'b1, 8'h01, 1'b1, 3'd0};
        tab[12] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0};
        tab[13] = '{8'hFF, 1'b0, 8'h02, 1'b1, 3'd1};
        tab[14] = '{8'hFF, 1'b0, 8'h00, 1'b1, 3'd1};
        tab[15] = '{8'hFF, 1'b1, 8'h04, 1'b1, 3'd2};

        do_reset();
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_sel", 32'(out_sel), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);

        for (int k = 0; k < 16; k++) begin
            in_valid  = tab[k].v;
            out_ready = tab[k].r;
            @(negedge clk);
            chk($sformatf("tab%0d_in_ready", k), 32'(in_ready), 32'(tab[k].ir));
            @(posedge clk);
            #1;
            chk($sformatf("tab%0d_out_valid", k), 32'(out_valid), 32'(tab[k].ov));
            chk($sformatf("tab%0d_out_sel", k), 32'(out_sel), 32'(tab[k].sel));
            chk($sformatf("tab%0d_out_data", k), 32'(out_data), 32'(chdata(int'(tab[k].sel))));
        end

        // Asynchronous reset while a word is held.
        out_ready = 1'b0;
        chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out_data", 32'(out_data), 32'd0);
        chk("async_rst_out_sel", 32'(out_sel), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 8'h00;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd0);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Round-robin wrap, all channels valid; expected words queued as driven.
        @(posedge clk);
        #1;
        for (int k = 0; k < 11; k++) begin
            in_valid  = (k < 10) ? 8'hFF : 8'h00;
            out_ready = 1'b1;
            if (k < 10) sb.push_back('{chdata(k % 8), 3'(k % 8)});
            @(negedge clk);
            if (k < 10) chk($sformatf("rr%0d_in_ready", k), 32'(in_ready), 32'(8'h01 << (k % 8)));
            if (k > 0) chk($sformatf("rr%0d_no_bubble", k), 32'(out_valid), 32'd1);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("rr_sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk($sformatf("rr%0d_sel", k), 32'(out_sel), 32'(e.sel));
                    chk($sformatf("rr%0d_data", k), 32'(out_data), 32'(e.data));
                end
            end
            @(posedge clk);
            #1;
        end
        chk("rr_sb_drained", 32'(sb.size()), 32'd0);
        chk("rr_idle_out_valid", 32'(out_valid), 32'd0);
        chk("rr_idle_sel_hold", 32'(out_sel), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux8to1.md
Name: rr_mux8to1

Overview:
- 8-to-1 round-robin collector: gathers one word from eight valid/ready input channels and emits it on a single output stream, tagged with the 3-bit source channel index in out_sel.
- It is the gather side of the 1-to-8 channel demultiplexer; downstream logic can route out_data back through a demux using out_sel.
- One registered output stage with fair arbitration and full backpressure.

Parameters:
- DATA_W, 8, width of each channel data word.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  8  per-channel valid; bit i belongs to channel i.
- in_data  input  8*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  8  per-channel accept; at most one bit is high in any cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  DATA_W  registered data word.
- out_sel  output  3  registered source channel index of out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_data=0, out_sel=3'b000, priority pointer=0 (channel 0 has highest priority first). in_ready=0 while rst is high.
- Transfers:
  - Input transfer on channel i occurs in a cycle where in_valid[i] && in_ready[i].
  - Output transfer occurs in a cycle where out_valid && out_ready.
- Load condition: can_load = !out_valid || out_ready (the register is empty or is being drained this cycle).
- Arbitration is combinational, over in_valid only:
  - Search starts at the pointer and proceeds upward modulo 8.
  - The first asserted channel wins; this produces grant (one-hot) and win_idx.
- in_ready[i] = can_load && grant[i]. in_ready has a combinational path from out_ready; this is intentional. in_ready never depends on in_data.
- On a clock edge with can_load and any in_valid set:
  - out_data <= selected data.
  - out_sel <= win_idx.
  - out_valid <= 1.
  - pointer <= (win_idx+1) mod 8, wrapping from 7 to 0.
- On a clock edge with can_load and no in_valid set: out_valid <= 0; out_data, out_sel and pointer hold.
- When out_valid && !out_ready: out_valid, out_data and out_sel hold stable, all in_ready=0, and the pointer holds.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 word/cycle when out_ready is held high.
- Simultaneous drain and load in the same edge: the new word replaces the old one with no bubble.
- Fairness: with all 8 channels continuously valid and out_ready=1, grants run 0,1,...,7,0,... Any channel waits at most 7 accepted words.
- An input channel may drop in_valid before it is granted; this has no side effects.
- Reset asserted mid-transfer: the output word is discarded immediately (out_valid=0 asynchronously). The pointer returns to 0.
- All 3-bit index arithmetic is modulo 8; there are no illegal states.

Decomposition:
- Shared package mux_pkg:
  - NUM_CH=8.
  - SEL_W=3.
  - Function onehot_to_idx (8 -> 3 bits).
- Sub-module rr_arbiter8:
  - Inputs: clk, rst, req[7:0], advance.
  - Outputs: grant[7:0], grant_idx[2:0], any_grant.
  - Contents: the pointer register and the rotate-priority-encode logic.
  - The top instantiates it with advance = can_load && any_grant and owns the output register.

Test Plan:
- Reset: assert rst mid-cycle with out_valid=1 -> out_valid, out_data and out_sel drop to 0 immediately. After release with in_valid=8'h00 -> in_ready=8'h00 and out_valid=0.
- Single channel: in_valid=8'b0010_0000, channel 5 data=8'hA5, out_ready=1 -> in_ready=8'b0010_0000. Next cycle out_valid=1, out_data=8'hA5, out_sel=3'd5.
- Round-robin wrap: in_valid=8'hFF held, channel i data=8'h10+i, out_ready=1 for 10 cycles after reset -> out_sel sequence 0,1,2,3,4,5,6,7,0,1 with matching data.
- Backpressure: out_valid=1, out_sel=2, out_ready=0 for 3 cycles with in_valid=8'h81 -> in_ready=8'h00 and output stable for all 3 cycles. When out_ready rises -> channel 7 is accepted (pointer=3), then channel 0.
- Back-to-back drain+load: in_valid=8'h0C, out_ready=1 continuously -> out_sel alternates 2,3,2,3 with out_valid continuously high and no bubble.
- Idle after traffic: drop all in_valid with out_ready=1 -> out_valid goes 0 the next cycle, out_data and out_sel hold their last values, and the pointer is unchanged.
